// File: rtl/tt_proj_mux_ctrl.sv
// Project multiplexer controller: serial address load, drain/reset-hold guarded
// switching, per-project input fan-out with gated clocks, output mux to the pads.
module tt_proj_mux_ctrl #(
    parameter int N_PROJ = 24,
    parameter int ADDR_W = 5,
    parameter int GUARD  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sel_data,
    input  logic                 sel_load,
    input  logic                 pad_rst_n,
    input  logic [7:0]           pad_ui_in,
    input  logic [7:0]           pad_uio_in,
    output logic [N_PROJ*18-1:0] iw_bus,
    output logic [N_PROJ-1:0]    ena,
    input  logic [N_PROJ*24-1:0] ow_bus,
    output logic [7:0]           pad_uo_out,
    output logic [7:0]           pad_uio_out,
    output logic [7:0]           pad_uio_oe,
    output logic [ADDR_W-1:0]    cur_addr,
    output logic                 active
);
    localparam int CNT_W = $clog2(ADDR_W + 1);
    localparam int GRD_W = (GUARD > 1) ? $clog2(GUARD) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(ADDR_W);
    localparam logic [GRD_W-1:0] GRD_LOAD = GRD_W'(GUARD - 1);

    typedef enum logic [1:0] {IDLE, DRAIN, RST_HOLD, RUN} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              load_prev_q, load_prev_d;
    logic [GRD_W-1:0]  grd_q, grd_d;
    logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
    logic [N_PROJ-1:0] ena_q, ena_d;
    logic              active_q, active_d;
    logic [1:0]        prst_sync_q, prst_sync_d;
    logic [N_PROJ-1:0] clk_en_q, clk_en_d;
    logic [N_PROJ-1:0] run_sel;
    logic              accept;
    logic              commit;
    logic              addr_ok;

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        load_prev_d = load_prev_q;
        grd_d       = grd_q;
        cur_addr_d  = cur_addr_q;
        prst_sync_d = {prst_sync_q[0], pad_rst_n};
        accept      = (state_q == IDLE) || (state_q == RUN);
        commit      = 1'b0;
        addr_ok     = (int'(shift_q) < N_PROJ);

        // The loader is frozen while a switch is in flight, edge detector included.
        if (accept) begin
            load_prev_d = sel_load;
            if (sel_load) begin
                shift_d = (shift_q << 1) | ADDR_W'(sel_data);
                if (!load_prev_q) begin
                    cnt_d = CNT_W'(1);
                end else if (cnt_q < CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else if (load_prev_q && (cnt_q >= CNT_MAX)) begin
                commit = 1'b1;
            end
        end

        case (state_q)
            IDLE, RUN: begin
                if (commit) begin
                    state_d = DRAIN;
                    grd_d   = GRD_LOAD;
                end
            end
            DRAIN: begin
                if (grd_q == '0) begin
                    cur_addr_d = shift_q;
                    if (addr_ok) begin
                        state_d = RST_HOLD;
                        grd_d   = GRD_LOAD;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    grd_d = grd_q - 1'b1;
                end
            end
            RST_HOLD: begin
                if (grd_q == '0) begin
                    state_d = RUN;
                end else begin
                    grd_d = grd_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        active_d = (state_d == RUN);
        for (int k = 0; k < N_PROJ; k++) begin
            ena_d[k] = ((state_d == RST_HOLD) || (state_d == RUN)) &&
                       (cur_addr_d == ADDR_W'(k));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            cnt_q       <= '0;
            load_prev_q <= 1'b0;
            grd_q       <= '0;
            cur_addr_q  <= '0;
            ena_q       <= '0;
            active_q    <= 1'b0;
            prst_sync_q <= '0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            load_prev_q <= load_prev_d;
            grd_q       <= grd_d;
            cur_addr_q  <= cur_addr_d;
            ena_q       <= ena_d;
            active_q    <= active_d;
            prst_sync_q <= prst_sync_d;
        end
    end

    // Gate enables change only while clk is low, so the AND gate cannot chop a pulse.
    assign clk_en_d = ena_q;

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_en_q <= '0;
        end else begin
            clk_en_q <= clk_en_d;
        end
    end

    assign run_sel = active_q ? ena_q : '0;

    always_comb begin
        iw_bus      = '0;
        pad_uo_out  = '0;
        pad_uio_out = '0;
        pad_uio_oe  = '0;
        for (int k = 0; k < N_PROJ; k++) begin
            iw_bus[k*18 +: 18] = {run_sel[k] ? pad_uio_in : 8'h00,
                                  run_sel[k] ? pad_ui_in  : 8'h00,
                                  run_sel[k] & prst_sync_q[1],
                                  clk & clk_en_q[k]};
            if (run_sel[k]) begin
                {pad_uio_oe, pad_uio_out, pad_uo_out} = ow_bus[k*24 +: 24];
            end
        end
    end

    assign ena      = ena_q;
    assign active   = active_q;
    assign cur_addr = cur_addr_q;
endmodule

// File: doc/tt_proj_mux_ctrl.md
Name: tt_proj_mux_ctrl

Overview:
- Sits directly upstream of the per-project wrappers.
- Receives pad-side user I/O and a serial project-select interface.
- Drives exactly one wrapper's packed input word and ena; muxes the selected wrapper's packed output word back to the pads.
- Sequences every project switch through a disable/reset guard so no wrapper sees a partial select.

Parameters:
- N_PROJ, 24: number of attached project wrappers.
- ADDR_W, 5: select address width; an address >= N_PROJ means no project.
- GUARD, 4: cycle count for each guard phase (DRAIN and RST_HOLD); minimum 1.

Ports:
- clk  in  1  system clock, also forwarded as the project clock.
- rst_n  in  1  asynchronous active-low reset.
- sel_data  in  1  serial select bit, MSB first.
- sel_load  in  1  high while shifting the select address.
- pad_rst_n  in  1  user project reset from pad, asynchronous.
- pad_ui_in  in  8  user inputs.
- pad_uio_in  in  8  user bidir inputs.
- iw_bus  out  N_PROJ*18  per-project packed inputs; slice k = {uio_in, ui_in, rst_n, clk}.
- ena  out  N_PROJ  per-project enable, one-hot or zero.
- ow_bus  in  N_PROJ*24  per-project packed outputs; slice k = {uio_oe, uio_out, uo_out}.
- pad_uo_out  out  8  selected uo_out.
- pad_uio_out  out  8  selected uio_out.
- pad_uio_oe  out  8  selected uio_oe.
- cur_addr  out  ADDR_W  currently committed address.
- active  out  1  high in RUN with a valid address.

Behaviour:
Reset (rst_n low, asynchronous):
- State IDLE; shift register, bit counter and cur_addr are 0.
- All ena bits 0; iw_bus all 0; pad outputs and oe 0; active 0.
- The pad_rst_n 2-flop synchroniser resets to 0.

States: IDLE (none selected), DRAIN, RST_HOLD, RUN.

Shift:
- Accepted only in IDLE and RUN. Each clk with sel_load=1 shifts sel_data into the LSB of an ADDR_W shift register.
- A saturating bit counter tracks shifted bits and clears when sel_load rises.
- More than ADDR_W bits: the last ADDR_W bits are kept.

Commit:
- A commit occurs on the first cycle sel_load samples 0 after sampling 1, with the counter >= ADDR_W.
- Fewer bits: the load is discarded and the current state and selection are unchanged.
- On commit, the next cycle enters DRAIN: all ena=0, all project rst_n bits 0, GUARD-cycle counter loaded.
- After GUARD cycles in DRAIN, cur_addr <= shift register.
- If the address is valid: enter RST_HOLD with ena[cur_addr]=1 and its rst_n bit held 0 for GUARD cycles, then RUN.
- If the address is invalid: enter IDLE.
- Committing the same address still runs the full sequence.

sel_load during DRAIN or RST_HOLD:
- Ignored: no shift, no counter update, no edge detection.
- Shifting resumes on the first cycle back in IDLE or RUN.

RUN:
- Selected iw slice: clk bit = clk (combinational forward); rst_n bit = synchronised pad_rst_n; ui_in/uio_in = pad inputs (combinational).
- Non-selected slices: all bits 0, including clk.
- Pad outputs = selected ow slice, combinational, zero latency.
- In IDLE, DRAIN and RST_HOLD, pad_uo_out, pad_uio_out and pad_uio_oe are 0.
- active = 1 only in RUN.

Clock gating of iw clk bits uses a glitch-free gate; the enable is a registered state bit.

Asynchronous reset mid-sequence: immediate return to reset values; no commit survives.

Test Plan:
- Reset state: assert rst_n=0 with random pad inputs -> ena=0, iw_bus=0, pad outputs 0, active=0, cur_addr=0.
- Select 3: shift 00011 and drop sel_load at cycle t.
  - Cycles t+1..t+4: DRAIN, ena=0.
  - Cycle t+5: ena=0x000008, project 3 rst_n bit 0.
  - Cycle t+9: RUN, rst_n bit follows synced pad_rst_n, active=1.
- Output mux: in RUN on 3, drive ow slice 3 = 0xA55A3C and other slices 0xFFFFFF -> pad_uio_oe=0xA5, pad_uio_out=0x5A, pad_uo_out=0x3C. Check pad_ui_in=0x81 appears only in slice 3.
- Invalid address: from RUN on 3, shift 11000 (24) -> DRAIN, then IDLE. Check ena=0, pad outputs 0, cur_addr=24, active=0.
- Short load: shift 3 bits then drop sel_load while in RUN on 3 -> no state change, ena unchanged. Then a 7-bit shift ending 00101 -> selects 5.
- Reset mid-switch: assert rst_n low in RST_HOLD -> all outputs reset the same cycle. After release: IDLE, and a later select of 0 works.
